// File: rtl/ifu_fetch.sv
// Instruction-fetch unit: owns the PC, fetches from imem over a
// req/gnt/rvalid handshake and hands (instr, instr_pc) to decode.
//
// Ports:
//   clk, reset      : rising-edge clock, async active-low reset
//   this_pc         : current PC, fed to the external next-PC logic
//   next_pc         : loaded into this_pc when decode consumes
//   flush, flush_pc : redirect request and target
//   imem_req/addr   : fetch request and byte address (addr = this_pc)
//   imem_gnt        : request accepted
//   imem_rvalid/rdata : fetch response
//   instr_valid/instr/instr_pc/instr_ready : decode handshake
//   fetch_err       : sticky illegal-PC flag
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] IMEM_BYTES = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] this_pc,
    input  logic [31:0] next_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN,
        S_ERR
    } state_t;

    state_t      state;
    state_t      nxt;
    logic        ld;
    logic [31:0] pc_d;
    logic        gnt_q;
    logic        f_ok;
    logic        d_ok;

    // Window top computed in 33 bits so it cannot wrap.
    function automatic logic pc_ok(input logic [31:0] pc);
        logic [32:0] lo;
        logic [32:0] hi;
        lo = {1'b0, RESET_PC};
        hi = lo + {1'b0, IMEM_BYTES};
        return (pc[1:0] == 2'b00) &&
               ({1'b0, pc} >= lo) && ({1'b0, pc} < hi);
    endfunction

    // Grant only counts while a request is actually on the bus;
    // the reset cycle sits in REQ with imem_req still low.
    assign gnt_q     = imem_req & imem_gnt;
    assign imem_addr = this_pc;
    assign f_ok      = pc_ok(flush_pc);
    assign d_ok      = pc_ok(pc_d);

    always_comb begin
        nxt  = state;
        ld   = 1'b0;
        pc_d = next_pc;
        unique case (state)
            S_REQ: begin
                if (flush) begin
                    ld   = 1'b1;
                    pc_d = flush_pc;
                    if (gnt_q)     nxt = S_DRAIN;
                    else if (f_ok) nxt = S_REQ;
                    else           nxt = S_ERR;
                end else if (gnt_q) begin
                    nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    ld   = 1'b1;
                    pc_d = flush_pc;
                    // A response arriving with the flush is simply dropped.
                    if (!imem_rvalid) nxt = S_DRAIN;
                    else if (f_ok)    nxt = S_REQ;
                    else              nxt = S_ERR;
                end else if (imem_rvalid) begin
                    nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    ld   = 1'b1;
                    pc_d = flush_pc;
                    nxt  = f_ok ? S_REQ : S_ERR;
                end else if (instr_ready) begin
                    ld  = 1'b1;
                    nxt = pc_ok(next_pc) ? S_REQ : S_ERR;
                end
            end
            S_DRAIN: begin
                if (flush) begin
                    ld   = 1'b1;
                    pc_d = flush_pc;
                end
                // fetch_err set earlier means this drain leads to ERR.
                if (imem_rvalid) begin
                    if (fetch_err || (flush && !f_ok)) nxt = S_ERR;
                    else                               nxt = S_REQ;
                end
            end
            S_ERR: begin
                nxt = S_ERR;
            end
            default: begin
                nxt = S_ERR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_REQ;
            this_pc     <= RESET_PC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            fetch_err   <= 1'b0;
        end else begin
            state       <= nxt;
            imem_req    <= (nxt == S_REQ);
            instr_valid <= (nxt == S_HOLD);
            if (ld) this_pc <= pc_d;
            if (ld && !d_ok) fetch_err <= 1'b1;
            if (state == S_WAIT && nxt == S_HOLD) begin
                instr    <= imem_rdata;
                instr_pc <= this_pc;
            end
        end
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction-fetch unit that owns the architectural PC register and drives the current PC to the next-PC logic. It loads the next-PC value back into the PC register each time decode consumes an instruction. It fetches from instruction memory over a request/grant/response handshake and presents each fetched word with its PC to decode over a valid/ready handshake. Flush redirect and misaligned/out-of-range PC detection are included.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
IMEM_BYTES, 32'h0000_1000, size of legal fetch window starting at RESET_PC

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
this_pc  output  32  current PC register, fed to next-PC logic
next_pc  input  32  next-PC value computed from this_pc, sampled on consume
flush  input  1  redirect request, highest priority
flush_pc  input  32  redirect target
imem_req  output  1  fetch request
imem_addr  output  32  fetch byte address
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response data valid
imem_rdata  input  32  response instruction word
instr_valid  output  1  instr/instr_pc valid to decode
instr  output  32  fetched instruction
instr_pc  output  32  PC of instr
instr_ready  input  1  decode consumes instr this cycle
fetch_err  output  1  sticky illegal-PC error

Behaviour:
- reset low, asynchronously: this_pc=RESET_PC, state=REQ, imem_req=0 (registered), instr_valid=0, instr=0, instr_pc=0, fetch_err=0. The first request is issued in the first cycle after reset releases.
- imem_req=1 only in REQ. imem_addr=this_pc at all times. The address is stable while req is high and not granted.
- States: REQ, WAIT, HOLD, DRAIN, ERR.
- REQ: when imem_gnt=1, go to WAIT.
- WAIT: when imem_rvalid=1, register instr<=imem_rdata and instr_pc<=this_pc, set instr_valid<=1, and go to HOLD.
- HOLD: instr_valid=1. instr and instr_pc are held stable until consumed. When instr_ready=1: this_pc<=next_pc, instr_valid<=0, go to REQ.
- Latency: with gnt in the request cycle and rvalid one cycle later, instr_valid rises 2 cycles after req rises. Peak throughput is 1 instruction per 3 cycles.
- flush=1 in any state except ERR:
  - this_pc<=flush_pc and instr_valid<=0.
  - From WAIT, or from REQ with imem_gnt=1 in the same cycle, go to DRAIN. Otherwise go to REQ.
  - flush beats a simultaneous instr_ready; next_pc is ignored that cycle.
- DRAIN: no request is issued. The first imem_rvalid is discarded (instr is unchanged), then go to REQ. A flush in DRAIN updates this_pc and stays in DRAIN.
- PC legality is checked on every PC load (next_pc on consume, flush_pc on flush). A PC is illegal if [1:0]!=0 or it lies outside [RESET_PC, RESET_PC+IMEM_BYTES).
  - On an illegal load: this_pc takes the value anyway, fetch_err<=1, instr_valid<=0, go to ERR.
  - If an outstanding response exists, go to DRAIN first, then to ERR instead of REQ.
- ERR: imem_req=0 and instr_valid=0. fetch_err stays 1 and flush is ignored. Only reset leaves ERR.
- imem_rvalid outside WAIT/DRAIN and imem_gnt outside REQ are ignored.
- Address arithmetic is plain 32-bit with no wrap detection beyond the window check. RESET_PC+IMEM_BYTES is computed in 33 bits so the top boundary never wraps.

Test Plan:
- Reset then sequential fetch: gnt immediate, rvalid +1, rdata 0x3C010000, next_pc=this_pc+4, ready held 1 -> instr_pc 0x3000, 0x3004, 0x3008, each valid 2 cycles after req. imem_addr matches instr_pc.
- Backpressure: ready=0 for 5 cycles in HOLD -> instr and instr_pc are unchanged, no new req, this_pc stays 0x3000. On ready, this_pc becomes next_pc.
- Stalled grant: gnt low 4 cycles -> req stays 1 and imem_addr stays 0x3004; the request completes after gnt.
- Flush in WAIT: flush_pc=0x3100 -> the pending rdata 0xDEADBEEF is dropped (instr_valid stays 0). The next req addr is 0x3100, and the delivered instr_pc is 0x3100.
- Flush and instr_ready in the same HOLD cycle, with next_pc=0x3008 and flush_pc=0x3200 -> this_pc=0x3200.
- Illegal PC:
  - next_pc=0x3002 on consume -> fetch_err=1, no further req, flush ignored.
  - next_pc=0x4000 -> same result.
  - Async reset mid-WAIT -> all outputs return to reset values immediately.
